// File: rtl/vx_wb_arbiter.sv
// vx_wb_arbiter
//   Merges the ALU/branch result stream and the memory (load response) stream
//   into one registered writeback bundle. Load responses are buffered in a
//   DEPTH-entry FIFO. The ALU producer is stalled whenever it requests but
//   does not win. The arbiter picks one winner per cycle, and the winner
//   loads the output register.
//
//   Handshakes:
//     ALU side: a request is alu_valid && alu_wb != WB_NO. It is consumed on a
//               rising edge where alu_stall is low. While alu_stall is high,
//               the producer holds every alu_* input stable. A valid input
//               with WB_NO is consumed at once and never stalls.
//     MEM side: a response is accepted on a rising edge where mem_valid and
//               mem_ready are both high and mem_wb != WB_NO. mem_ready is
//               taken from the registered count only; a pop in the same
//               cycle does not make room early.
//
//   Ports:
//     clk, reset          single clock, synchronous active-high reset
//     alu_*               ALU result bundle in, alu_stall out
//     mem_*               load response bundle in, mem_ready out
//     out_*               registered writeback bundle. out_valid is the thread
//                         mask. The losing result bus is zero. A bubble has
//                         out_wb == WB_NO and all other fields zero.
//     dbg_count_o         FIFO occupancy (debug)
//     dbg_last_grant_o    last winner, 0 = ALU, 1 = MEM (debug)
module vx_wb_arbiter #(
  parameter  int NT    = 4,
  parameter  int NW    = 8,
  parameter  int DEPTH = 4,
  localparam int NW_W  = $clog2(NW),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  // ALU pipe
  input  logic              alu_valid,
  input  logic [NT*32-1:0]  alu_result,
  input  logic [4:0]        alu_rd,
  input  logic [1:0]        alu_wb,
  input  logic [31:0]       alu_PC_next,
  input  logic [NT-1:0]     alu_thread_mask,
  input  logic [NW_W-1:0]   alu_warp_num,
  output logic              alu_stall,
  // memory pipe
  input  logic              mem_valid,
  input  logic [NT*32-1:0]  mem_result,
  input  logic [4:0]        mem_rd,
  input  logic [1:0]        mem_wb,
  input  logic [31:0]       mem_PC_next,
  input  logic [NT-1:0]     mem_thread_mask,
  input  logic [NW_W-1:0]   mem_warp_num,
  output logic              mem_ready,
  // writeback bundle
  output logic [NT*32-1:0]  out_alu_result,
  output logic [NT*32-1:0]  out_mem_result,
  output logic [4:0]        out_rd,
  output logic [1:0]        out_wb,
  output logic [31:0]       out_PC_next,
  output logic [NT-1:0]     out_valid,
  output logic [NW_W-1:0]   out_warp_num,
  // debug
  output logic [CNT_W-1:0]  dbg_count_o,
  output logic              dbg_last_grant_o
);

  localparam logic [1:0] WB_NO = 2'd0;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] HI_CNT   = CNT_W'(DEPTH - 1);

  typedef struct packed {
    logic [NT*32-1:0] result;
    logic [4:0]       rd;
    logic [1:0]       wb;
    logic [31:0]      pc_next;
    logic [NT-1:0]    mask;
    logic [NW_W-1:0]  warp;
  } entry_t;

  // FIFO storage has no reset; the pointers and count alone define validity.
  entry_t             fifo_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               last_grant_q, last_grant_d;

  logic [NT*32-1:0]   out_alu_result_q, out_alu_result_d;
  logic [NT*32-1:0]   out_mem_result_q, out_mem_result_d;
  logic [4:0]         out_rd_q, out_rd_d;
  logic [1:0]         out_wb_q, out_wb_d;
  logic [31:0]        out_pc_q, out_pc_d;
  logic [NT-1:0]      out_mask_q, out_mask_d;
  logic [NW_W-1:0]    out_warp_q, out_warp_d;

  logic   alu_req, fifo_ne, pressure, push, pop;
  logic   grant_alu, grant_mem;
  entry_t head, push_entry;

  assign alu_req  = alu_valid && (alu_wb != WB_NO);
  assign fifo_ne  = (count_q != '0);
  // The pressure rule pops whenever count >= DEPTH-1. With at most one push
  // per cycle, occupancy therefore stays at DEPTH-1 in normal operation.
  // mem_ready still guards the full case so the producer contract holds.
  assign pressure = fifo_ne && (count_q >= HI_CNT);
  assign mem_ready = (count_q != FULL_CNT);
  assign push     = mem_valid && mem_ready && (mem_wb != WB_NO);
  assign head     = fifo_q[rd_ptr_q];

  assign push_entry = '{result: mem_result, rd: mem_rd, wb: mem_wb,
                        pc_next: mem_PC_next, mask: mem_thread_mask,
                        warp: mem_warp_num};

  // Arbitration. When both sources contend below the pressure threshold,
  // the source that did not win last time goes first.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (pressure) begin
      grant_mem = 1'b1;
    end else if (alu_req && fifo_ne) begin
      if (last_grant_q) grant_alu = 1'b1;
      else              grant_mem = 1'b1;
    end else if (alu_req) begin
      grant_alu = 1'b1;
    end else if (fifo_ne) begin
      grant_mem = 1'b1;
    end
  end

  assign pop       = grant_mem;
  assign alu_stall = alu_req && !grant_alu;

  // FIFO bookkeeping. DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    last_grant_d = (grant_alu || grant_mem) ? grant_mem : last_grant_q;
  end

  // Next output bundle. A bubble leaves everything zero, so out_wb = WB_NO.
  always_comb begin
    out_alu_result_d = '0;
    out_mem_result_d = '0;
    out_rd_d         = '0;
    out_wb_d         = WB_NO;
    out_pc_d         = '0;
    out_mask_d       = '0;
    out_warp_d       = '0;
    if (grant_alu) begin
      out_alu_result_d = alu_result;
      out_rd_d         = alu_rd;
      out_wb_d         = alu_wb;
      out_pc_d         = alu_PC_next;
      out_mask_d       = alu_thread_mask;
      out_warp_d       = alu_warp_num;
    end else if (grant_mem) begin
      out_mem_result_d = head.result;
      out_rd_d         = head.rd;
      out_wb_d         = head.wb;
      out_pc_d         = head.pc_next;
      out_mask_d       = head.mask;
      out_warp_d       = head.warp;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      last_grant_q     <= 1'b0;
      out_alu_result_q <= '0;
      out_mem_result_q <= '0;
      out_rd_q         <= '0;
      out_wb_q         <= WB_NO;
      out_pc_q         <= '0;
      out_mask_q       <= '0;
      out_warp_q       <= '0;
    end else begin
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      last_grant_q     <= last_grant_d;
      out_alu_result_q <= out_alu_result_d;
      out_mem_result_q <= out_mem_result_d;
      out_rd_q         <= out_rd_d;
      out_wb_q         <= out_wb_d;
      out_pc_q         <= out_pc_d;
      out_mask_q       <= out_mask_d;
      out_warp_q       <= out_warp_d;
    end
  end

  assign out_alu_result   = out_alu_result_q;
  assign out_mem_result   = out_mem_result_q;
  assign out_rd           = out_rd_q;
  assign out_wb           = out_wb_q;
  assign out_PC_next      = out_pc_q;
  assign out_valid        = out_mask_q;
  assign out_warp_num     = out_warp_q;
  assign dbg_count_o      = count_q;
  assign dbg_last_grant_o = last_grant_q;

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Testbench for vx_wb_arbiter (NT=4, NW=8, DEPTH=4).
// The directed sequences queue their hand-derived output order. A negedge
// monitor pops and compares every non-bubble output. Bubbles must be all-zero.
module tb_vx_wb_arbiter;

  localparam int NT = 4;
  localparam int NW = 8;
  localparam int DEPTH = 4;
  localparam int NW_W = 3;
  localparam int EW = 2*NT*32 + 5 + 2 + 32 + NT + NW_W;

  localparam logic [1:0] WB_NO  = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

  logic              clk, reset;
  logic              alu_valid, mem_valid;
  logic [NT*32-1:0]  alu_result, mem_result;
  logic [4:0]        alu_rd, mem_rd;
  logic [1:0]        alu_wb, mem_wb;
  logic [31:0]       alu_PC_next, mem_PC_next;
  logic [NT-1:0]     alu_thread_mask, mem_thread_mask;
  logic [NW_W-1:0]   alu_warp_num, mem_warp_num;
  logic              alu_stall, mem_ready;
  logic [NT*32-1:0]  out_alu_result, out_mem_result;
  logic [4:0]        out_rd;
  logic [1:0]        out_wb;
  logic [31:0]       out_PC_next;
  logic [NT-1:0]     out_valid;
  logic [NW_W-1:0]   out_warp_num;
  logic [2:0]        dbg_count;
  logic              dbg_last_grant;

  vx_wb_arbiter #(.NT(NT), .NW(NW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_result(alu_result), .alu_rd(alu_rd),
    .alu_wb(alu_wb), .alu_PC_next(alu_PC_next),
    .alu_thread_mask(alu_thread_mask), .alu_warp_num(alu_warp_num),
    .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
    .mem_wb(mem_wb), .mem_PC_next(mem_PC_next),
    .mem_thread_mask(mem_thread_mask), .mem_warp_num(mem_warp_num),
    .mem_ready(mem_ready),
    .out_alu_result(out_alu_result), .out_mem_result(out_mem_result),
    .out_rd(out_rd), .out_wb(out_wb), .out_PC_next(out_PC_next),
    .out_valid(out_valid), .out_warp_num(out_warp_num),
    .dbg_count_o(dbg_count), .dbg_last_grant_o(dbg_last_grant)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;

  function automatic logic [31:0] pc_of(input logic [4:0] rd);
    return 32'h0000_1000 + {25'd0, rd, 2'b00};
  endfunction

  function automatic logic [EW-1:0] mk(input logic is_mem, input logic [31:0] r,
                                       input logic [4:0] rd, input logic [1:0] wb,
                                       input logic [3:0] m, input logic [2:0] w);
    logic [NT*32-1:0] bus;
    logic [NT*32-1:0] zero;
    bus  = {NT{r}};
    zero = '0;
    if (is_mem) return {zero, bus, rd, wb, pc_of(rd), m, w};
    else        return {bus, zero, rd, wb, pc_of(rd), m, w};
  endfunction

  task automatic exp_alu(input logic [4:0] rd, input logic [31:0] r,
                         input logic [3:0] m, input logic [2:0] w);
    exp_q.push_back(mk(1'b0, r, rd, WB_ALU, m, w));
  endtask

  task automatic exp_mem(input logic [4:0] rd, input logic [31:0] r,
                         input logic [3:0] m, input logic [2:0] w);
    exp_q.push_back(mk(1'b1, r, rd, WB_MEM, m, w));
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    if (mon_en) begin
      act = {out_alu_result, out_mem_result, out_rd, out_wb, out_PC_next,
             out_valid, out_warp_num};
      tests++;
      if (out_wb != WB_NO) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got %0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            fails++;
            $display("FAIL out_bundle: got %0h expected %0h", act, e);
          end
        end
      end else if (act !== '0) begin
        fails++;
        $display("FAIL bubble_zero: got %0h expected 0", act);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [1:0] wb, input logic [4:0] rd,
                           input logic [31:0] r, input logic [3:0] m, input logic [2:0] w);
    alu_valid       = v;
    alu_wb          = wb;
    alu_rd          = rd;
    alu_result      = {NT{r}};
    alu_PC_next     = pc_of(rd);
    alu_thread_mask = m;
    alu_warp_num    = w;
  endtask

  task automatic drive_mem(input logic v, input logic [1:0] wb, input logic [4:0] rd,
                           input logic [31:0] r, input logic [3:0] m, input logic [2:0] w);
    mem_valid       = v;
    mem_wb          = wb;
    mem_rd          = rd;
    mem_result      = {NT{r}};
    mem_PC_next     = pc_of(rd);
    mem_thread_mask = m;
    mem_warp_num    = w;
  endtask

  task automatic alu_idle();
    drive_alu(1'b0, WB_NO, 5'd0, 32'd0, 4'd0, 3'd0);
  endtask

  task automatic mem_idle();
    drive_mem(1'b0, WB_NO, 5'd0, 32'd0, 4'd0, 3'd0);
  endtask

  task automatic chk_stall(input logic exp);
    #1;
    check("alu_stall", 256'(alu_stall), 256'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    alu_idle();
    mem_idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_wb",   256'(out_wb), 256'(0));
    check("rst_out_alu",  256'(out_alu_result), 256'(0));
    check("rst_out_mem",  256'(out_mem_result), 256'(0));
    check("rst_mem_ready", 256'(mem_ready), 256'(1));
    check("rst_count",    256'(dbg_count), 256'(0));
    check("rst_last",     256'(dbg_last_grant), 256'(0));
    reset = 1'b0;
    mon_en = 1'b1;

    // ALU only: visible one edge after the request.
    exp_alu(5'd5, 32'h1111_1111, 4'b1111, 3'd3);
    tick();
    drive_alu(1'b1, WB_ALU, 5'd5, 32'h1111_1111, 4'b1111, 3'd3);
    chk_stall(1'b0);
    tick();
    check("alu_lat_wb", 256'(out_wb), 256'(WB_ALU));
    check("alu_lat_rd", 256'(out_rd), 256'(5));
    alu_idle();
    chk_stall(1'b0);

    // MEM only: no bypass, so output appears after the edge following the push.
    exp_mem(5'd7, 32'hDEAD_BEEF, 4'b1111, 3'd6);
    tick();
    drive_mem(1'b1, WB_MEM, 5'd7, 32'hDEAD_BEEF, 4'b1111, 3'd6);
    tick();
    mem_idle();
    check("mem_nobypass_wb", 256'(out_wb), 256'(WB_NO));
    check("mem_count1", 256'(dbg_count), 256'(1));
    tick();
    check("mem_lat_wb", 256'(out_wb), 256'(WB_MEM));
    check("mem_lat_rd", 256'(out_rd), 256'(7));
    check("mem_count0", 256'(dbg_count), 256'(0));

    // Contention below threshold; last_grant starts at MEM.
    exp_alu(5'd10, 32'hA000_0001, 4'hF, 3'd1);
    exp_mem(5'd11, 32'hB000_0001, 4'hF, 3'd2);
    exp_alu(5'd13, 32'hA000_0002, 4'h3, 3'd4);
    exp_mem(5'd12, 32'hB000_0002, 4'hC, 3'd5);
    exp_alu(5'd14, 32'hA000_0003, 4'h5, 3'd7);
    tick();
    drive_alu(1'b1, WB_ALU, 5'd10, 32'hA000_0001, 4'hF, 3'd1);
    drive_mem(1'b1, WB_MEM, 5'd11, 32'hB000_0001, 4'hF, 3'd2);
    chk_stall(1'b0);
    tick();
    drive_alu(1'b1, WB_ALU, 5'd13, 32'hA000_0002, 4'h3, 3'd4);
    drive_mem(1'b1, WB_MEM, 5'd12, 32'hB000_0002, 4'hC, 3'd5);
    chk_stall(1'b1);
    tick();
    mem_idle();
    chk_stall(1'b0);
    tick();
    drive_alu(1'b1, WB_ALU, 5'd14, 32'hA000_0003, 4'h5, 3'd7);
    chk_stall(1'b1);
    tick();
    chk_stall(1'b0);
    tick();
    alu_idle();
    repeat (2) tick();

    // Pressure: ALU continuously valid, one push per cycle.
    exp_alu(5'd20, 32'hC000_0020, 4'hF, 3'd0);
    exp_mem(5'd21, 32'hD000_0021, 4'hF, 3'd1);
    exp_alu(5'd22, 32'hC000_0022, 4'h1, 3'd2);
    exp_mem(5'd23, 32'hD000_0023, 4'h2, 3'd3);
    exp_alu(5'd25, 32'hC000_0025, 4'h4, 3'd4);
    exp_mem(5'd24, 32'hD000_0024, 4'h8, 3'd5);
    exp_mem(5'd26, 32'hD000_0026, 4'h6, 3'd6);
    exp_alu(5'd28, 32'hC000_0028, 4'h9, 3'd7);
    exp_mem(5'd27, 32'hD000_0027, 4'hA, 3'd0);
    exp_mem(5'd29, 32'hD000_0029, 4'hB, 3'd1);
    tick();
    drive_alu(1'b1, WB_ALU, 5'd20, 32'hC000_0020, 4'hF, 3'd0);
    drive_mem(1'b1, WB_MEM, 5'd21, 32'hD000_0021, 4'hF, 3'd1);
    chk_stall(1'b0);
    tick();
    drive_alu(1'b1, WB_ALU, 5'd22, 32'hC000_0022, 4'h1, 3'd2);
    drive_mem(1'b1, WB_MEM, 5'd23, 32'hD000_0023, 4'h2, 3'd3);
    chk_stall(1'b1);
    tick();
    drive_mem(1'b1, WB_MEM, 5'd24, 32'hD000_0024, 4'h8, 3'd5);
    chk_stall(1'b0);
    tick();
    drive_alu(1'b1, WB_ALU, 5'd25, 32'hC000_0025, 4'h4, 3'd4);
    drive_mem(1'b1, WB_MEM, 5'd26, 32'hD000_0026, 4'h6, 3'd6);
    chk_stall(1'b1);
    tick();
    drive_mem(1'b1, WB_MEM, 5'd27, 32'hD000_0027, 4'hA, 3'd0);
    chk_stall(1'b0);
    tick();
    check("press_count3a", 256'(dbg_count), 256'(3));
    check("press_ready", 256'(mem_ready), 256'(1));
    drive_alu(1'b1, WB_ALU, 5'd28, 32'hC000_0028, 4'h9, 3'd7);
    drive_mem(1'b1, WB_MEM, 5'd29, 32'hD000_0029, 4'hB, 3'd1);
    chk_stall(1'b1);
    tick();
    check("press_count3b", 256'(dbg_count), 256'(3));
    check("press_last_mem", 256'(dbg_last_grant), 256'(1));
    mem_idle();
    chk_stall(1'b1);
    tick();
    check("press_count2", 256'(dbg_count), 256'(2));
    chk_stall(1'b0);
    tick();
    alu_idle();
    repeat (2) tick();
    check("press_drained", 256'(dbg_count), 256'(0));

    // WB_NO on both sides: consumed/dropped, bubble out, last_grant kept.
    tick();
    drive_alu(1'b1, WB_NO, 5'd3, 32'h5555_5555, 4'hF, 3'd2);
    drive_mem(1'b1, WB_NO, 5'd4, 32'h6666_6666, 4'hF, 3'd2);
    chk_stall(1'b0);
    tick();
    check("wbno_out_wb", 256'(out_wb), 256'(WB_NO));
    check("wbno_out_alu", 256'(out_alu_result), 256'(0));
    check("wbno_out_mem", 256'(out_mem_result), 256'(0));
    check("wbno_count", 256'(dbg_count), 256'(0));
    check("wbno_last", 256'(dbg_last_grant), 256'(1));
    alu_idle();
    mem_idle();
    tick();

    // Reset with three entries queued: q3..q5 must never appear.
    exp_alu(5'd1, 32'hE000_0001, 4'hF, 3'd1);
    exp_mem(5'd2, 32'hF000_0002, 4'hF, 3'd2);
    exp_alu(5'd3, 32'hE000_0003, 4'h7, 3'd3);
    exp_mem(5'd4, 32'hF000_0004, 4'h1, 3'd4);
    exp_alu(5'd5, 32'hE000_0005, 4'h2, 3'd5);
    tick();
    drive_alu(1'b1, WB_ALU, 5'd1, 32'hE000_0001, 4'hF, 3'd1);
    drive_mem(1'b1, WB_MEM, 5'd2, 32'hF000_0002, 4'hF, 3'd2);
    tick();
    drive_alu(1'b1, WB_ALU, 5'd3, 32'hE000_0003, 4'h7, 3'd3);
    drive_mem(1'b1, WB_MEM, 5'd4, 32'hF000_0004, 4'h1, 3'd4);
    tick();
    drive_mem(1'b1, WB_MEM, 5'd6, 32'hF000_0006, 4'h3, 3'd6);
    tick();
    drive_alu(1'b1, WB_ALU, 5'd5, 32'hE000_0005, 4'h2, 3'd5);
    drive_mem(1'b1, WB_MEM, 5'd7, 32'hF000_0007, 4'h4, 3'd7);
    tick();
    drive_mem(1'b1, WB_MEM, 5'd8, 32'hF000_0008, 4'h5, 3'd0);
    tick();
    check("pre_rst_count", 256'(dbg_count), 256'(3));
    reset = 1'b1;
    alu_idle();
    mem_idle();
    tick();
    reset = 1'b0;
    check("mid_rst_out_wb", 256'(out_wb), 256'(WB_NO));
    check("mid_rst_out_rd", 256'(out_rd), 256'(0));
    check("mid_rst_out_mem", 256'(out_mem_result), 256'(0));
    check("mid_rst_ready", 256'(mem_ready), 256'(1));
    check("mid_rst_count", 256'(dbg_count), 256'(0));
    check("mid_rst_last", 256'(dbg_last_grant), 256'(0));
    repeat (6) tick();

    // Final drain, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("exp_q_empty", 256'(exp_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
